apb_node_reg: RTL and testbench
===============================

APB_NODE_REG -- requirements
Module: apb_node_reg

Interface
REQ-001 SHALL have parameter NB_MASTER, default 8, number of master ports (>=1).
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter APB_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, access-phase timeout in cycles; 0 disables the timeout.
REQ-005 SHALL have port clk_i  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports s_psel_i, s_penable_i, s_pwrite_i  in  1 each  upstream APB control.
REQ-008 SHALL have ports s_paddr_i  in  APB_ADDR_WIDTH; s_pwdata_i  in  APB_DATA_WIDTH; s_pstrb_i  in  APB_DATA_WIDTH/8  upstream request.
REQ-009 SHALL have ports s_prdata_o  out  APB_DATA_WIDTH; s_pready_o, s_pslverr_o  out  1  upstream response.
REQ-010 SHALL have ports m_psel_o  out  NB_MASTER  one-hot select; m_penable_o, m_pwrite_o  out  1  shared downstream control.
REQ-011 SHALL have ports m_paddr_o  out  APB_ADDR_WIDTH; m_pwdata_o  out  APB_DATA_WIDTH; m_pstrb_o  out  APB_DATA_WIDTH/8  shared downstream request.
REQ-012 SHALL have ports m_prdata_i  in  NB_MASTER x APB_DATA_WIDTH; m_pready_i, m_pslverr_i  in  NB_MASTER  downstream responses.
REQ-013 SHALL have ports start_addr_i, end_addr_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive rule bounds; rule_en_i  in  NB_MASTER  per-rule enable.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, ERR.
REQ-015 IDLE: when s_psel_i=1 and s_penable_i=1, the block SHALL register paddr, pwrite, pwdata, pstrb and the decode result in that cycle (T).
REQ-016 Decode SHALL match rule i when rule_en_i[i]=1 and start_addr_i[i] <= paddr <= end_addr_i[i], unsigned; on multiple matches the lowest index SHALL win.
REQ-017 On a match, the FSM SHALL go to SETUP at T+1: m_psel_o one-hot on the winner, m_penable_o=0.
REQ-018 The FSM SHALL go from SETUP to ACCESS unconditionally at T+2: m_psel_o held, m_penable_o=1.
REQ-019 In ACCESS, when m_pready_i[sel]=1, the block SHALL latch m_prdata_i[sel] and m_pslverr_i[sel], deassert m_psel_o/m_penable_o and go to RESP.
REQ-020 RESP SHALL last exactly one cycle with s_pready_o=1, s_pslverr_o and s_prdata_o equal to the latched values, then go to IDLE; minimum upstream latency is T+3.
REQ-021 With no match, the FSM SHALL go to ERR at T+1: s_pready_o=1, s_pslverr_o=1, s_prdata_o=0, no m_psel_o asserted, then IDLE.
REQ-022 s_pready_o SHALL be 0 in IDLE, SETUP and ACCESS; s_prdata_o and s_pslverr_o SHALL be 0 outside RESP/ERR.
REQ-023 A cycle counter SHALL clear on entering ACCESS and increment each ACCESS cycle without pready; with TIMEOUT_CYCLES>0, on the cycle where the count equals TIMEOUT_CYCLES-1 without pready, the block SHALL deassert master signals and go to RESP with s_pslverr_o=1, s_prdata_o=0.
REQ-024 Pready and timeout in the same cycle: pready SHALL win and its data/slverr SHALL be returned.
REQ-025 m_paddr_o, m_pwrite_o, m_pwdata_o, m_pstrb_o SHALL hold the registered request from T+1 until the next capture.
REQ-026 m_pready_i of unselected ports SHALL be ignored; changes to address rules after T SHALL not affect the transfer in flight.
REQ-027 Upstream request inputs SHALL be ignored outside IDLE; a new transfer can be captured no earlier than the cycle after RESP/ERR.
REQ-028 The counter SHALL be wide enough for TIMEOUT_CYCLES without wrap-around.

Reset
REQ-029 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE, the counter to 0, and all outputs and registered request fields to 0.
REQ-030 A reset during SETUP/ACCESS SHALL abandon the transfer: m_psel_o=0 from the edge after reset, with no upstream response.

Verification
REQ-031 Rules: 0x1000-0x1FFF on port 2; read 0x1004; slave pready at the first ACCESS cycle with prdata 0xCAFE0001 -> m_psel_o=0b100 at T+1, s_pready_o=1 with 0xCAFE0001 and pslverr=0 at T+3.
REQ-032 Write 0x9000 with no matching rule -> ERR at T+1, s_pready_o=1, s_pslverr_o=1, m_psel_o never asserted.
REQ-033 TIMEOUT_CYCLES=4, slave never ready -> 4 ACCESS cycles, then RESP with pslverr=1, prdata=0, m_psel_o=0.
REQ-034 Rules 0 and 3 both cover 0x2000, rule 0 disabled -> port 3 selected; re-enable rule 0 -> port 0 selected.
REQ-035 Assert rst_i during ACCESS -> next cycle all outputs 0, FSM IDLE; a following transfer completes normally.
REQ-036 Pready on the same cycle as timeout expiry with pslverr=0 -> response is the slave data with pslverr=0.

Source files
------------

// File: rtl/apb_node_reg.sv
// APB 1-to-N node: decodes an upstream transfer against per-port address rules,
// replays it on the selected downstream port with a registered request, and returns the response.
module apb_node_reg #(
    parameter int NB_MASTER      = 8,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,

    input  logic                                  s_psel_i,
    input  logic                                  s_penable_i,
    input  logic                                  s_pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]             s_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]             s_pwdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0]           s_pstrb_i,
    output logic [APB_DATA_WIDTH-1:0]             s_prdata_o,
    output logic                                  s_pready_o,
    output logic                                  s_pslverr_o,

    output logic [NB_MASTER-1:0]                  m_psel_o,
    output logic                                  m_penable_o,
    output logic                                  m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]             m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]             m_pwdata_o,
    output logic [APB_DATA_WIDTH/8-1:0]           m_pstrb_o,
    input  logic [NB_MASTER*APB_DATA_WIDTH-1:0]   m_prdata_i,
    input  logic [NB_MASTER-1:0]                  m_pready_i,
    input  logic [NB_MASTER-1:0]                  m_pslverr_i,

    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [NB_MASTER*APB_ADDR_WIDTH-1:0]   end_addr_i,
    input  logic [NB_MASTER-1:0]                  rule_en_i
);

    localparam int STRB_W = APB_DATA_WIDTH / 8;
    // Two spare codes above TIMEOUT_CYCLES-1 so the counter can saturate instead of wrapping.
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        RESP   = 3'd3,
        ERR    = 3'd4
    } state_e;

    state_e                      state_q,     state_d;
    logic [CNT_W-1:0]            cnt_q,       cnt_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
    logic                        pwrite_q,    pwrite_d;
    logic [APB_DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
    logic [STRB_W-1:0]           pstrb_q,     pstrb_d;
    logic [NB_MASTER-1:0]        m_psel_q,    m_psel_d;
    logic                        m_penable_q, m_penable_d;
    logic                        s_pready_q,  s_pready_d;
    logic                        s_pslverr_q, s_pslverr_d;
    logic [APB_DATA_WIDTH-1:0]   s_prdata_q,  s_prdata_d;

    logic [NB_MASTER-1:0]        hit_s;
    logic [NB_MASTER-1:0]        dec_s;
    logic [APB_DATA_WIDTH-1:0]   sel_rdata_s;
    logic                        sel_ready_s;
    logic                        sel_err_s;
    logic                        timeout_hit_s;

    // Address decode: per-rule range hit, then isolate the lowest set bit as the winner.
    always_comb begin
        hit_s = {NB_MASTER{1'b0}};
        for (int i = 0; i < NB_MASTER; i++) begin
            hit_s[i] = rule_en_i[i]
                && (s_paddr_i >= start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])
                && (s_paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]);
        end
        dec_s = hit_s & (~hit_s + NB_MASTER'(1));
    end

    // Response mux keyed by the registered one-hot select, so unselected ports are ignored.
    always_comb begin
        sel_rdata_s = {APB_DATA_WIDTH{1'b0}};
        sel_ready_s = 1'b0;
        sel_err_s   = 1'b0;
        for (int i = 0; i < NB_MASTER; i++) begin
            sel_rdata_s = sel_rdata_s | (m_prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH]
                                         & {APB_DATA_WIDTH{m_psel_q[i]}});
            sel_ready_s = sel_ready_s | (m_pready_i[i] & m_psel_q[i]);
            sel_err_s   = sel_err_s   | (m_pslverr_i[i] & m_psel_q[i]);
        end
        timeout_hit_s = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST);
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        m_psel_d    = {NB_MASTER{1'b0}};
        m_penable_d = 1'b0;
        s_pready_d  = 1'b0;
        s_pslverr_d = 1'b0;
        s_prdata_d  = {APB_DATA_WIDTH{1'b0}};

        case (state_q)
            IDLE: begin
                if (s_psel_i && s_penable_i) begin
                    paddr_d  = s_paddr_i;
                    pwrite_d = s_pwrite_i;
                    pwdata_d = s_pwdata_i;
                    pstrb_d  = s_pstrb_i;
                    if (|dec_s) begin
                        state_d  = SETUP;
                        m_psel_d = dec_s;
                    end else begin
                        state_d     = ERR;
                        s_pready_d  = 1'b1;
                        s_pslverr_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d     = ACCESS;
                m_psel_d    = m_psel_q;
                m_penable_d = 1'b1;
                cnt_d       = {CNT_W{1'b0}};
            end
            ACCESS: begin
                // A ready slave takes priority over a timeout expiring in the same cycle.
                if (sel_ready_s) begin
                    state_d     = RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = sel_err_s;
                    s_prdata_d  = sel_rdata_s;
                end else if (timeout_hit_s) begin
                    state_d     = RESP;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                end else begin
                    state_d     = ACCESS;
                    m_psel_d    = m_psel_q;
                    m_penable_d = 1'b1;
                    cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            paddr_q     <= {APB_ADDR_WIDTH{1'b0}};
            pwrite_q    <= 1'b0;
            pwdata_q    <= {APB_DATA_WIDTH{1'b0}};
            pstrb_q     <= {STRB_W{1'b0}};
            m_psel_q    <= {NB_MASTER{1'b0}};
            m_penable_q <= 1'b0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
            s_prdata_q  <= {APB_DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            s_pready_q  <= s_pready_d;
            s_pslverr_q <= s_pslverr_d;
            s_prdata_q  <= s_prdata_d;
        end
    end

    assign m_psel_o    = m_psel_q;
    assign m_penable_o = m_penable_q;
    assign m_pwrite_o  = pwrite_q;
    assign m_paddr_o   = paddr_q;
    assign m_pwdata_o  = pwdata_q;
    assign m_pstrb_o   = pstrb_q;
    assign s_pready_o  = s_pready_q;
    assign s_pslverr_o = s_pslverr_q;
    assign s_prdata_o  = s_prdata_q;

endmodule

// File: tb/tb_apb_node_reg.sv
// Directed self-checking bench for apb_node_reg: 4 ports, 4-cycle access timeout.
module tb_apb_node_reg;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic              clk;
    logic              rst_i;
    logic              s_psel_i, s_penable_i, s_pwrite_i;
    logic [AW-1:0]     s_paddr_i;
    logic [DW-1:0]     s_pwdata_i;
    logic [DW/8-1:0]   s_pstrb_i;
    logic [DW-1:0]     s_prdata_o;
    logic              s_pready_o, s_pslverr_o;
    logic [NB-1:0]     m_psel_o;
    logic              m_penable_o, m_pwrite_o;
    logic [AW-1:0]     m_paddr_o;
    logic [DW-1:0]     m_pwdata_o;
    logic [DW/8-1:0]   m_pstrb_o;
    logic [NB*DW-1:0]  m_prdata_i;
    logic [NB-1:0]     m_pready_i, m_pslverr_i;
    logic [NB*AW-1:0]  start_addr_i, end_addr_i;
    logic [NB-1:0]     rule_en_i;

    int checks;
    int failures;

    apb_node_reg #(
        .NB_MASTER(NB), .APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .s_psel_i(s_psel_i), .s_penable_i(s_penable_i), .s_pwrite_i(s_pwrite_i),
        .s_paddr_i(s_paddr_i), .s_pwdata_i(s_pwdata_i), .s_pstrb_i(s_pstrb_i),
        .s_prdata_o(s_prdata_o), .s_pready_o(s_pready_o), .s_pslverr_o(s_pslverr_o),
        .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
        .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o), .m_pstrb_o(m_pstrb_o),
        .m_prdata_i(m_prdata_i), .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .rule_en_i(rule_en_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        s_paddr_i   = addr;
        s_pwrite_i  = wr;
        s_pwdata_i  = wdata;
        s_pstrb_i   = 4'hF;
        s_psel_i    = 1'b1;
        s_penable_i = 1'b1;
    endtask

    task automatic end_xfer();
        s_psel_i    = 1'b0;
        s_penable_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_i = 1'b1;
        s_psel_i = 1'b0; s_penable_i = 1'b0; s_pwrite_i = 1'b0;
        s_paddr_i = 32'h0; s_pwdata_i = 32'h0; s_pstrb_i = 4'h0;
        m_prdata_i = '0; m_pready_i = 4'b0000; m_pslverr_i = 4'b0000;
        start_addr_i = '0; end_addr_i = '0; rule_en_i = 4'b0000;
        start_addr_i[0*AW +: AW] = 32'h0000_0000; end_addr_i[0*AW +: AW] = 32'h0000_0FFF;
        start_addr_i[2*AW +: AW] = 32'h0000_1000; end_addr_i[2*AW +: AW] = 32'h0000_1FFF;
        start_addr_i[3*AW +: AW] = 32'h0000_1F00; end_addr_i[3*AW +: AW] = 32'h0000_20FF;

        // Reset state
        tick(); tick();
        check("rst_pready", 32'(s_pready_o), 32'h0);
        check("rst_psel",   32'(m_psel_o),   32'h0);
        check("rst_prdata", s_prdata_o,      32'h0);
        check("rst_paddr",  m_paddr_o,       32'h0);
        rst_i = 1'b0;
        tick();

        // Read 0x1004 routed to port 2, slave ready in first ACCESS cycle
        rule_en_i = 4'b0100;
        m_prdata_i[2*DW +: DW] = 32'hCAFE_0001;
        m_pready_i = 4'b0100;
        start_xfer(32'h0000_1004, 1'b0, 32'h1111_2222);
        tick();
        check("rd_setup_psel",    32'(m_psel_o),    32'h4);
        check("rd_setup_penable", 32'(m_penable_o), 32'h0);
        check("rd_setup_paddr",   m_paddr_o,        32'h0000_1004);
        check("rd_setup_pwrite",  32'(m_pwrite_o),  32'h0);
        tick();
        check("rd_access_psel",    32'(m_psel_o),    32'h4);
        check("rd_access_penable", 32'(m_penable_o), 32'h1);
        check("rd_access_pready",  32'(s_pready_o),  32'h0);
        tick();
        check("rd_resp_pready",  32'(s_pready_o),  32'h1);
        check("rd_resp_prdata",  s_prdata_o,       32'hCAFE_0001);
        check("rd_resp_pslverr", 32'(s_pslverr_o), 32'h0);
        check("rd_resp_psel",    32'(m_psel_o),    32'h0);
        end_xfer();
        tick();
        check("rd_idle_pready", 32'(s_pready_o), 32'h0);
        check("rd_idle_prdata", s_prdata_o,      32'h0);

        // Write 0x9000 with no matching rule
        start_xfer(32'h0000_9000, 1'b1, 32'hA5A5_5A5A);
        tick();
        check("err_pready",  32'(s_pready_o),  32'h1);
        check("err_pslverr", 32'(s_pslverr_o), 32'h1);
        check("err_prdata",  s_prdata_o,       32'h0);
        check("err_psel",    32'(m_psel_o),    32'h0);
        check("err_pwdata",  m_pwdata_o,       32'hA5A5_5A5A);
        end_xfer();
        tick();
        check("err_idle_psel",   32'(m_psel_o),   32'h0);
        check("err_idle_pready", 32'(s_pready_o), 32'h0);

        // Timeout: port 0 never ready, other ports' pready must be ignored
        rule_en_i = 4'b0001;
        m_prdata_i[0*DW +: DW] = 32'hDEAD_0000;
        m_pready_i = 4'b1110;
        start_xfer(32'h0000_0040, 1'b0, 32'h0);
        tick();
        check("to_setup_psel", 32'(m_psel_o), 32'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("to_access_penable", 32'(m_penable_o), 32'h1);
            check("to_access_pready",  32'(s_pready_o),  32'h0);
        end
        tick();
        check("to_resp_pready",  32'(s_pready_o),  32'h1);
        check("to_resp_pslverr", 32'(s_pslverr_o), 32'h1);
        check("to_resp_prdata",  s_prdata_o,       32'h0);
        check("to_resp_psel",    32'(m_psel_o),    32'h0);
        end_xfer();
        tick();

        // Pready arriving on the timeout cycle wins
        m_pready_i = 4'b0000;
        m_prdata_i[0*DW +: DW] = 32'h1234_5678;
        start_xfer(32'h0000_0080, 1'b0, 32'h0);
        tick(); tick(); tick(); tick(); tick();
        check("race_last_penable", 32'(m_penable_o), 32'h1);
        m_pready_i = 4'b0001;
        tick();
        check("race_pready",  32'(s_pready_o),  32'h1);
        check("race_pslverr", 32'(s_pslverr_o), 32'h0);
        check("race_prdata",  s_prdata_o,       32'h1234_5678);
        end_xfer();
        m_pready_i = 4'b0000;
        tick();

        // Overlapping rules 0 and 3 at 0x2000: rule 0 disabled picks port 3
        start_addr_i[0*AW +: AW] = 32'h0000_2000; end_addr_i[0*AW +: AW] = 32'h0000_2FFF;
        rule_en_i = 4'b1100;
        m_prdata_i[0*DW +: DW] = 32'h0000_0A0A;
        m_prdata_i[3*DW +: DW] = 32'h3333_3333;
        m_pslverr_i = 4'b1000;
        m_pready_i = 4'b1111;
        start_xfer(32'h0000_2000, 1'b0, 32'h0);
        tick();
        check("ovl3_psel", 32'(m_psel_o), 32'h8);
        tick(); tick();
        check("ovl3_prdata",  s_prdata_o,       32'h3333_3333);
        check("ovl3_pslverr", 32'(s_pslverr_o), 32'h1);
        end_xfer();
        tick();

        // Rule 0 re-enabled wins; rule changes after capture are ignored
        rule_en_i = 4'b1101;
        start_xfer(32'h0000_2000, 1'b0, 32'h0);
        tick();
        check("ovl0_psel", 32'(m_psel_o), 32'h1);
        rule_en_i = 4'b0000;
        tick();
        check("ovl0_access_psel", 32'(m_psel_o), 32'h1);
        tick();
        check("ovl0_prdata",  s_prdata_o,       32'h0000_0A0A);
        check("ovl0_pslverr", 32'(s_pslverr_o), 32'h0);
        end_xfer();
        m_pslverr_i = 4'b0000;
        tick();

        // Reset during ACCESS abandons the transfer
        rule_en_i = 4'b0100;
        m_pready_i = 4'b0000;
        start_xfer(32'h0000_1008, 1'b1, 32'h7777_8888);
        tick(); tick();
        check("rst_mid_penable_pre", 32'(m_penable_o), 32'h1);
        rst_i = 1'b1;
        end_xfer();
        tick();
        check("rst_mid_psel",    32'(m_psel_o),    32'h0);
        check("rst_mid_penable", 32'(m_penable_o), 32'h0);
        check("rst_mid_pready",  32'(s_pready_o),  32'h0);
        check("rst_mid_paddr",   m_paddr_o,        32'h0);
        check("rst_mid_pwdata",  m_pwdata_o,       32'h0);
        rst_i = 1'b0;
        tick();
        check("rst_mid_no_resp", 32'(s_pready_o), 32'h0);

        // Transfer after reset completes normally
        m_prdata_i[2*DW +: DW] = 32'hCAFE_0002;
        m_pready_i = 4'b0100;
        start_xfer(32'h0000_1010, 1'b0, 32'h0);
        tick();
        check("post_rst_psel", 32'(m_psel_o), 32'h4);
        tick(); tick();
        check("post_rst_pready", 32'(s_pready_o), 32'h1);
        check("post_rst_prdata", s_prdata_o,      32'hCAFE_0002);
        end_xfer();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
